// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter slice.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_DIV_W  = 16;

    // ST_HOLD is reached only when the build enables bursts.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: the first valid requester strictly after
// the pointer wins, wrapping around.
module rr_select #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // NOTE: every output and temporary gets a default first, so no latch is inferred.
    always_comb begin
        onehot   = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(pointer) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && valid[cand_idx]) begin
                found            = 1'b1;
                onehot[cand_idx] = 1'b1;
                index            = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART serializer between NUM_REQ byte producers.
// Optional macro UART_TX_ARB_BURST_EN adds req_last_i so an owner may keep the line.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                    NUM_REQ       = 4,
    parameter int                    BUSY_TIMEOUT  = 15,
    parameter logic [UART_DIV_W-1:0] RESET_DIVIDER = 16'd1
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
`ifdef UART_TX_ARB_BURST_EN
    input  logic [NUM_REQ-1:0]             req_last_i,
`endif
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             grant_o,
    input  logic [UART_DIV_W-1:0]          cfg_clock_divider_i,
    input  logic                           cfg_two_stop_bits_i,
    input  logic                           cfg_parity_bit_i,
    input  logic                           cfg_parity_even_i,
    output logic                           tx_write_o,
    output logic [UART_DATA_W-1:0]         tx_data_o,
    output logic [UART_DIV_W-1:0]          tx_clock_divider_o,
    output logic                           tx_two_stop_bits_o,
    output logic                           tx_parity_bit_o,
    output logic                           tx_parity_even_o,
    input  logic                           tx_busy_i,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int         IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] TIMEOUT_LAST = 4'(BUSY_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [3:0]         count_q;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_index;
    logic               pick_found;
    logic               frame_last;
`ifdef UART_TX_ARB_BURST_EN
    logic               last_q;
    assign frame_last = last_q;
`else
    assign frame_last = 1'b1;
`endif

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .valid   (req_valid_i),
        .pointer (ptr_q),
        .onehot  (pick_onehot),
        .index   (pick_index),
        .found   (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found && !tx_busy_i) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                req_ready_o = grant_o;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tx_busy_i)                    state_d = ST_WAIT_DONE;
                else if (count_q == TIMEOUT_LAST) state_d = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) state_d = frame_last ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                // Burst owner keeps the line; only its own valid can resume.
                if (req_valid_i[owner_q] && !tx_busy_i) state_d = ST_GRANT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE) | tx_busy_i;

    // NOTE: state is updated with non-blocking assignments only, so every process sees pre-edge values.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            ptr_q              <= IDX_W'(NUM_REQ - 1);
            owner_q            <= '0;
            count_q            <= '0;
            grant_o            <= '0;
            tx_write_o         <= 1'b0;
            tx_data_o          <= '0;
            timeout_o          <= 1'b0;
            tx_clock_divider_o <= RESET_DIVIDER;
            tx_two_stop_bits_o <= 1'b0;
            tx_parity_bit_o    <= 1'b0;
            tx_parity_even_o   <= 1'b0;
`ifdef UART_TX_ARB_BURST_EN
            last_q             <= 1'b1;
`endif
        end else begin
            timeout_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Line config follows cfg_* only while the serializer is quiet.
                    if (!tx_busy_i) begin
                        tx_clock_divider_o <= cfg_clock_divider_i;
                        tx_two_stop_bits_o <= cfg_two_stop_bits_i;
                        tx_parity_bit_o    <= cfg_parity_bit_i;
                        tx_parity_even_o   <= cfg_parity_even_i;
                    end
                    if (state_d == ST_GRANT) begin
                        grant_o <= pick_onehot;
                        owner_q <= pick_index;
                    end
                end
                ST_GRANT: begin
                    tx_data_o  <= req_data_i[UART_DATA_W*owner_q +: UART_DATA_W];
                    ptr_q      <= owner_q;
                    tx_write_o <= 1'b1;
                    count_q    <= '0;
`ifdef UART_TX_ARB_BURST_EN
                    last_q     <= req_last_i[owner_q];
`endif
                end
                ST_ISSUE: begin
                    if (tx_busy_i) begin
                        tx_write_o <= 1'b0;
                    end else if (count_q == TIMEOUT_LAST) begin
                        // Serializer never acknowledged: drop the byte and release.
                        tx_write_o <= 1'b0;
                        timeout_o  <= 1'b1;
                        grant_o    <= '0;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (state_d == ST_IDLE) grant_o <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
